step_motor_sequencer: RTL and testbench

STEP_MOTOR_SEQUENCER -- requirements
Module: step_motor_sequencer

---
 rtl/step_motor_pkg.sv | 19 +
 rtl/step_rate_gen.sv | 47 ++++
 rtl/step_motor_sequencer.sv | 145 ++++++++++++++
 tb/tb_step_motor_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/step_motor_pkg.sv
// rtl/step_motor_pkg.sv - shared state encoding, phase table and speed-shift width for the stepper sequencer
package step_motor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } motor_state_e;

    // Width of the speed field; the step period is DIV_BASE shifted right by it
    localparam int SPEED_W = 2;

    // Coil pattern {A,B,C,D}: even entries drive one coil, odd entries drive two
    localparam logic [3:0] PHASE_TABLE [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

endpackage

// File: rtl/step_rate_gen.sv
// rtl/step_rate_gen.sv - step period divider with restart input and one-cycle tick output
module step_rate_gen
    import step_motor_pkg::*;
#(
    parameter int DIV_BASE = 1000
) (
    input  logic               new_clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               restart,
    input  logic [SPEED_W-1:0] speed,
    output logic               tick
);

    localparam int DIV_W = $clog2(DIV_BASE);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [DIV_W-1:0]   period_m1;

    // Count up to period-1; speed is latched only at a period boundary so a
    // mid-period change stretches nothing already in flight
    always_comb begin
        period_m1 = DIV_W'((DIV_BASE >> speed_q) - 1);
        tick      = enable && (div_q == period_m1);
        div_d     = div_q;
        speed_d   = speed_q;
        if (restart || tick) begin
            div_d   = '0;
            speed_d = speed;
        end else if (enable) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider and latched speed registers
    always_ff @(posedge new_clk) begin
        if (rst) begin
            div_q   <= '0;
            speed_q <= '0;
        end else begin
            div_q   <= div_d;
            speed_q <= speed_d;
        end
    end

endmodule

// File: rtl/step_motor_sequencer.sv
// rtl/step_motor_sequencer.sv - stepper coil sequencer (IDLE/RUN/HOLD); STEP_COUNT_EN adds signed pos counter
module step_motor_sequencer
    import step_motor_pkg::*;
#(
    parameter int DIV_BASE   = 1000,
    parameter int HOLD_TICKS = 4
) (
    input  logic               new_clk,
    input  logic               rst,
    input  logic               run,
    input  logic               dir,
    input  logic               half_step,
    input  logic [SPEED_W-1:0] speed,
    output logic [3:0]         phase,
    output logic               step_pulse,
    output logic               busy
`ifdef STEP_COUNT_EN
    ,
    output logic signed [15:0] pos
`endif
);

    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    motor_state_e      state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              step_pulse_q, step_pulse_d;
    logic              tick;
    logic              restart;
    logic [2:0]        step_amt;

    step_rate_gen #(
        .DIV_BASE (DIV_BASE)
    ) u_rate (
        .new_clk (new_clk),
        .rst     (rst),
        .enable  (state_q != ST_IDLE),
        .restart (restart),
        .speed   (speed),
        .tick    (tick)
    );

    // Full mode from a single-coil entry moves one slot to realign onto two-coil entries
    always_comb begin
        step_amt = (half_step || !idx_q[0]) ? 3'd1 : 3'd2;
    end

`ifdef STEP_COUNT_EN
    logic signed [15:0] pos_q, pos_d;
    logic signed [16:0] pos_sum;

    // Next position with saturation at the 16-bit signed limits
    always_comb begin
        pos_sum = {pos_q[15], pos_q} +
                  (dir ? $signed({14'd0, step_amt}) : -$signed({14'd0, step_amt}));
        pos_d = pos_q;
        if (state_q == ST_RUN && tick) begin
            if (pos_sum > 17'sd32767) begin
                pos_d = 16'sh7fff;
            end else if (pos_sum < -17'sd32768) begin
                pos_d = -16'sh8000;
            end else begin
                pos_d = pos_sum[15:0];
            end
        end
    end

    // Position register
    always_ff @(posedge new_clk) begin
        if (rst) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;
`endif

    // Next state: a tick coinciding with run low still steps before holding
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        hold_d       = hold_q;
        step_pulse_d = 1'b0;
        restart      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_RUN;
                    restart = 1'b1;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    idx_d        = dir ? (idx_q + step_amt) : (idx_q - step_amt);
                    step_pulse_d = 1'b1;
                end
                if (!run) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                    restart = 1'b1;
                end
            end
            ST_HOLD: begin
                if (run) begin
                    state_d = ST_RUN;
                    restart = 1'b1;
                end else if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, index, hold count and strobe registers
    always_ff @(posedge new_clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd1;
            hold_q       <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            hold_q       <= hold_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign phase      = (state_q == ST_IDLE) ? 4'b0000 : PHASE_TABLE[idx_q];
    assign step_pulse = step_pulse_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_step_motor_sequencer.sv
// tb/tb_step_motor_sequencer.sv - directed and randomized checks of step_motor_sequencer against a behavioural model
module tb_step_motor_sequencer;

    localparam int DIV_BASE   = 8;
    localparam int HOLD_TICKS = 2;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    logic       new_clk = 1'b0;
    logic       rst;
    logic       run;
    logic       dir;
    logic       half_step;
    logic [1:0] speed;
    logic [3:0] phase;
    logic       step_pulse;
    logic       busy;
`ifdef STEP_COUNT_EN
    logic signed [15:0] pos;
`endif

    step_motor_sequencer #(
        .DIV_BASE   (DIV_BASE),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .new_clk    (new_clk),
        .rst        (rst),
        .run        (run),
        .dir        (dir),
        .half_step  (half_step),
        .speed      (speed),
        .phase      (phase),
        .step_pulse (step_pulse),
        .busy       (busy)
`ifdef STEP_COUNT_EN
        ,
        .pos        (pos)
`endif
    );

    always #5 new_clk = ~new_clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] ref_table [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                  4'b0010, 4'b0011, 4'b0001, 4'b1001};

    // Behavioural model: countdown of cycles left in the current period
    int m_mode  = M_IDLE;
    int m_left  = 0;
    int m_holds = 0;
    int m_idx   = 1;
    int m_pos   = 0;
    bit m_pulse = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int amt;
        m_pulse = 1'b0;
        if (rst) begin
            m_mode = M_IDLE;
            m_idx  = 1;
            m_pos  = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (run) begin
                    m_mode = M_RUN;
                    m_left = DIV_BASE >> speed;
                end
            end
            M_RUN: begin
                m_left--;
                if (m_left == 0) begin
                    amt     = (half_step || (m_idx % 2 == 0)) ? 1 : 2;
                    m_idx   = (m_idx + (dir ? amt : -amt) + 8) % 8;
                    m_pos   = m_pos + (dir ? amt : -amt);
                    if (m_pos > 32767)  m_pos = 32767;
                    if (m_pos < -32768) m_pos = -32768;
                    m_pulse = 1'b1;
                    m_left  = DIV_BASE >> speed;
                end
                if (!run) begin
                    m_mode  = M_HOLD;
                    m_holds = HOLD_TICKS;
                    m_left  = DIV_BASE >> speed;
                end
            end
            default: begin
                if (run) begin
                    m_mode = M_RUN;
                    m_left = DIV_BASE >> speed;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_holds--;
                        if (m_holds == 0) m_mode = M_IDLE;
                        m_left = DIV_BASE >> speed;
                    end
                end
            end
        endcase
    endtask

    task automatic cyc();
        @(posedge new_clk);
        model_step();
        @(negedge new_clk);
        chk("phase", 32'(phase), (m_mode == M_IDLE) ? 32'd0 : 32'(ref_table[m_idx]));
        chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
        chk("pulse", 32'(step_pulse), 32'(m_pulse));
`ifdef STEP_COUNT_EN
        chk("pos", 32'(pos), 32'(m_pos));
`endif
    endtask

    task automatic wait_pulse(output int ncyc);
        ncyc = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            ncyc++;
            if (m_pulse) break;
        end
        if (!m_pulse) chk("pulse_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    logic [3:0] rev_full [4] = '{4'b1001, 4'b0011, 4'b0110, 4'b1100};

    initial begin
        int n;
        rst = 1'b1; run = 1'b0; dir = 1'b1; half_step = 1'b1; speed = 2'd0;
        cyc();
        cyc();
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulse", 32'(step_pulse), 32'd0);
        rst = 1'b0;

        // Half-step forward, full wrap of the table
        run = 1'b1;
        wait_pulse(n);
        chk("half_first_phase", 32'(phase), 32'(4'b0100));
        for (int k = 0; k < 8; k++) begin
            wait_pulse(n);
            chk("half_period", 32'(n), 32'd8);
            chk("half_phase", 32'(phase), 32'(ref_table[(3 + k) % 8]));
        end

        // Drop run: hold 16 cycles then idle
        run = 1'b0;
        for (int k = 0; k < 16; k++) cyc();
        chk("hold_busy", 32'(busy), 32'd1);
        cyc();
        chk("hold_end_busy", 32'(busy), 32'd0);
        chk("hold_end_phase", 32'(phase), 32'd0);

        // Reassert run during hold
        run = 1'b1;
        wait_pulse(n);
        run = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        run = 1'b1;
        wait_pulse(n);
        chk("resume_latency", 32'(n), 32'd9);

        // Full-step reverse from idx 1
        do_reset();
        dir = 1'b0; half_step = 1'b0; run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_pulse(n);
            chk("full_rev_phase", 32'(phase), 32'(rev_full[k]));
        end

        // Half then full at idx 2: realign to odd entries
        do_reset();
        dir = 1'b1; half_step = 1'b1; run = 1'b1;
        wait_pulse(n);
        chk("realign_pre", 32'(phase), 32'(4'b0100));
        half_step = 1'b0;
        wait_pulse(n);
        chk("realign_step", 32'(phase), 32'(4'b0110));
        wait_pulse(n);
        chk("realign_odd1", 32'(phase), 32'(4'b0011));
        wait_pulse(n);
        chk("realign_odd2", 32'(phase), 32'(4'b1001));

        // Fast speed, then reset mid-run
        do_reset();
        speed = 2'd2; half_step = 1'b1; run = 1'b1;
        wait_pulse(n);
        wait_pulse(n);
        chk("speed2_period", 32'(n), 32'd2);
        rst = 1'b1;
        cyc();
        chk("midrst_phase", 32'(phase), 32'd0);
        chk("midrst_pulse", 32'(step_pulse), 32'd0);
        rst = 1'b0;
        cyc();
        chk("midrst_idx", 32'(phase), 32'(4'b1100));

`ifdef STEP_COUNT_EN
        do_reset();
        speed = 2'd0; dir = 1'b1; half_step = 1'b0; run = 1'b1;
        for (int k = 0; k < 5; k++) wait_pulse(n);
        dir = 1'b0; half_step = 1'b1;
        for (int k = 0; k < 3; k++) wait_pulse(n);
        chk("pos_final", 32'(pos), 32'd7);
`endif

        // Randomized stimulus
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) run = ~run;
            if ($urandom_range(0, 9) == 0)  dir = ~dir;
            if ($urandom_range(0, 9) == 0)  half_step = ~half_step;
            if ($urandom_range(0, 14) == 0) speed = 2'($urandom_range(0, 3));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
